// File: rtl/int_arb_pkg.sv
// -----------------------------------------------------------------------------
// int_arb_pkg
// Shared types and constants for the interrupt arbiter:
//   state_t  - arbiter FSM states (IDLE, ASSERT, WAIT_ACK)
//   ID_NONE  - src_id value presented when no source is granted
//   MAX_SRC  - largest supported number of request inputs
//   IDX_W    - width of a source index, wide enough for MAX_SRC sources
// -----------------------------------------------------------------------------
package int_arb_pkg;

  localparam int         MAX_SRC = 8;
  localparam int         IDX_W   = $clog2(MAX_SRC);
  localparam logic [7:0] ID_NONE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT   = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

endpackage

// File: rtl/int_arbiter_if.sv
// -----------------------------------------------------------------------------
// int_arbiter_if
// Bundle of peripheral/CPU-side signals of the interrupt arbiter.
//   irq_req   - level requests from peripherals (0->1 edge raises a request)
//   mask_we   - mask register write strobe
//   mask_din  - new mask value, bit=1 masks that source
//   id_rd     - one-cycle CPU read of the ID port; acts as the acknowledge
//   interrupt - registered interrupt line to the CPU
//   src_id    - granted source index, 8'hFF when nothing is granted
//   pending   - latched pending bits for status reads
// Modports: master = requesters/CPU side, slave = the arbiter.
// -----------------------------------------------------------------------------
interface int_arbiter_if #(
  parameter int N_SRC = 4
);

  logic [N_SRC-1:0] irq_req;
  logic             mask_we;
  logic [N_SRC-1:0] mask_din;
  logic             id_rd;
  logic             interrupt;
  logic [7:0]       src_id;
  logic [N_SRC-1:0] pending;

  modport master (
    output irq_req, mask_we, mask_din, id_rd,
    input  interrupt, src_id, pending
  );

  modport slave (
    input  irq_req, mask_we, mask_din, id_rd,
    output interrupt, src_id, pending
  );

endinterface

// File: rtl/int_prio_pick.sv
// -----------------------------------------------------------------------------
// int_prio_pick
// Combinational picker: returns the first set bit of `eligible`, searching
// upward from `start` and wrapping at N_SRC. With start tied to 0 this is a
// plain fixed-priority encoder (index 0 highest).
//   eligible - candidate vector
//   start    - search start index (must be < N_SRC)
//   found    - at least one candidate was set
//   idx      - index of the chosen candidate (0 when none found)
// -----------------------------------------------------------------------------
module int_prio_pick
  import int_arb_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0] eligible,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  int pos;

  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path leaves a value held and no latch is inferred.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int i = 0; i < N_SRC; i++) begin
      // start + i stays below 2*N_SRC, so one conditional subtract wraps it.
      pos = int'(start) + i;
      if (pos >= N_SRC) pos = pos - N_SRC;
      if (!found && eligible[pos]) begin
        found = 1'b1;
        idx   = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/int_arbiter.sv
// -----------------------------------------------------------------------------
// int_arbiter
// Shares the single CPU interrupt line between N_SRC peripheral requesters.
// Each request is edge-detected and latched as pending; pending & ~mask is the
// eligible set. One source is granted at a time: interrupt is driven high for
// exactly PULSE_LEN cycles and src_id carries the granted index until the CPU
// reads the ID port (id_rd), which clears that source's pending bit.
//
// Ports:
//   clk - system clock, all state updates on the rising edge
//   rst - synchronous, active-high reset
//   bus - int_arbiter_if.slave (irq_req, mask_we, mask_din, id_rd,
//         interrupt, src_id, pending)
//
// Build option:
//   INT_ARB_RR_EN defined   - round-robin arbitration starting at a pointer
//                             that moves to grant+1 on every grant.
//   INT_ARB_RR_EN undefined - fixed priority, index 0 highest; no pointer.
// -----------------------------------------------------------------------------
module int_arbiter
  import int_arb_pkg::*;
#(
  parameter int N_SRC     = 4,
  parameter int PULSE_LEN = 6
) (
  input  logic          clk,
  input  logic          rst,
  int_arbiter_if.slave  bus
);

  localparam int              CNT_W    = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN - 1);

  state_t           state_q, state_d;
  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q;
  logic [N_SRC-1:0] rise, clr, eligible;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] start_idx, pick_idx;
  logic             pick_found;
  logic             grant_take;
  logic             acked_q, acked_d;
  logic             irq_q, irq_d;
  logic [7:0]       src_id_q, src_id_d;

  assign rise     = bus.irq_req & ~prev_q;
  assign eligible = pend_q & ~mask_q;
  // A new edge wins over an acknowledge of the same source in the same cycle,
  // so the source stays pending and gets served again.
  assign pend_d   = (pend_q & ~clr) | rise;

  int_prio_pick #(.N_SRC(N_SRC)) u_pick (
    .eligible (eligible),
    .start    (start_idx),
    .found    (pick_found),
    .idx      (pick_idx)
  );

`ifdef INT_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q;

  always_ff @(posedge clk) begin
    if (rst)
      ptr_q <= '0;
    else if (grant_take)
      ptr_q <= (int'(pick_idx) == N_SRC - 1) ? '0 : pick_idx + 1'b1;
  end

  assign start_idx = ptr_q;
`else
  assign start_idx = '0;
`endif

  // Next-state and next-output logic. interrupt/src_id are computed here and
  // registered below, so they change on the same edge as the state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    acked_d    = acked_q;
    irq_d      = 1'b0;
    src_id_d   = src_id_q;
    clr        = '0;
    grant_take = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_take = 1'b1;
          grant_d    = pick_idx;
          src_id_d   = {{(8-IDX_W){1'b0}}, pick_idx};
          cnt_d      = CNT_LOAD;
          acked_d    = 1'b0;
          irq_d      = 1'b1;
          state_d    = ASSERT;
        end
      end

      ASSERT: begin
        // An early ack is recorded but never shortens the pulse.
        if (bus.id_rd) begin
          clr[grant_q] = 1'b1;
          src_id_d     = ID_NONE;
          acked_d      = 1'b1;
        end
        if (cnt_q == '0) begin
          state_d = (acked_q || bus.id_rd) ? IDLE : WAIT_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
          irq_d = 1'b1;
        end
      end

      WAIT_ACK: begin
        if (bus.id_rd) begin
          clr[grant_q] = 1'b1;
          src_id_d     = ID_NONE;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: every register, including the edge history, is reset so the
    // first cycle after reset cannot see a false rising edge or stale grant.
    if (rst) begin
      state_q  <= IDLE;
      prev_q   <= '0;
      pend_q   <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      acked_q  <= 1'b0;
      irq_q    <= 1'b0;
      src_id_q <= ID_NONE;
    end else begin
      state_q  <= state_d;
      prev_q   <= bus.irq_req;
      pend_q   <= pend_d;
      if (bus.mask_we) mask_q <= bus.mask_din;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      acked_q  <= acked_d;
      irq_q    <= irq_d;
      src_id_q <= src_id_d;
    end
  end

  assign bus.interrupt = irq_q;
  assign bus.src_id    = src_id_q;
  assign bus.pending   = pend_q;

endmodule

// File: tb/tb_int_arbiter.sv
`timescale 1ns/1ps
module tb_int_arbiter;

  localparam int         N    = 4;
  localparam int         P    = 6;
  localparam logic [7:0] NONE = 8'hFF;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  int_arbiter_if #(.N_SRC(N)) bus ();

  int_arbiter #(.N_SRC(N), .PULSE_LEN(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping and check
  // ---------------------------------------------------------------------------
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: service bookkeeping by age since grant, applied once per
  // rising edge with the inputs the bench drove for that edge.
  // ---------------------------------------------------------------------------
  typedef struct {
    int src;
    int at;
  } grant_t;

  grant_t     sb[$];
  bit         m_prev[N];
  bit         m_pend[N];
  bit         m_mask[N];
  bit         m_busy  = 1'b0;
  bit         m_acked = 1'b0;
  int         m_src   = 0;
  int         m_age   = 0;
  int         m_ptr   = 0;
  bit         exp_int = 1'b0;
  logic [7:0] exp_id  = NONE;
  bit         cut     = 1'b0;

  function automatic logic [N-1:0] pend_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic void model_step(input logic [N-1:0] req, input logic ack,
                                     input logic mw, input logic [N-1:0] md,
                                     input logic r);
    bit clr[N];
    bit old_pend[N];
    int pick;
    int s;
    cyc++;
    if (r) begin
      for (int i = 0; i < N; i++) begin
        m_prev[i] = 1'b0;
        m_pend[i] = 1'b0;
        m_mask[i] = 1'b0;
      end
      m_busy  = 1'b0;
      m_acked = 1'b0;
      m_ptr   = 0;
      exp_int = 1'b0;
      exp_id  = NONE;
      cut     = 1'b1;
      return;
    end
    for (int i = 0; i < N; i++) begin
      clr[i]      = 1'b0;
      old_pend[i] = m_pend[i];
    end
    if (m_busy) begin
      if (ack) begin
        clr[m_src] = 1'b1;
        m_acked    = 1'b1;
        exp_id     = NONE;
      end
      m_age++;
      if (m_age >= P && m_acked) m_busy = 1'b0;
    end else begin
      pick = -1;
      for (int k = 0; k < N; k++) begin
`ifdef INT_ARB_RR_EN
        s = (m_ptr + k) % N;
`else
        s = k;
`endif
        if (pick < 0 && old_pend[s] && !m_mask[s]) pick = s;
      end
      if (pick >= 0) begin
        m_busy  = 1'b1;
        m_acked = 1'b0;
        m_age   = 0;
        m_src   = pick;
        m_ptr   = (pick + 1) % N;
        exp_id  = 8'(pick);
        sb.push_back('{pick, cyc});
      end
    end
    for (int i = 0; i < N; i++) begin
      m_pend[i] = (m_pend[i] && !clr[i]) || (req[i] && !m_prev[i]);
      m_prev[i] = req[i];
      if (mw) m_mask[i] = md[i];
    end
    exp_int = m_busy && (m_age < P);
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: inputs change on the falling edge, model advances on the rising one
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [N-1:0] req, input logic ack, input logic mw,
                       input logic [N-1:0] md, input logic r);
    @(negedge clk);
    bus.irq_req  = req;
    bus.id_rd    = ack;
    bus.mask_we  = mw;
    bus.mask_din = md;
    rst          = r;
    @(posedge clk);
    model_step(req, ack, mw, md, r);
  endtask

  task automatic idle(input int n, input logic [N-1:0] req);
    for (int i = 0; i < n; i++) drive(req, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares levels every cycle, pops the scoreboard on each pulse
  // start and checks the pulse length at each pulse end.
  // ---------------------------------------------------------------------------
  bit     mon_en   = 1'b0;
  bit     last_int = 1'b0;
  int     plen     = 0;
  grant_t g;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("interrupt", 32'(bus.interrupt), 32'(exp_int));
        check("src_id",    32'(bus.src_id),    32'(exp_id));
        check("pending",   32'(bus.pending),   32'(pend_vec()));
        if (bus.interrupt === 1'b1) begin
          if (!last_int) begin
            plen = 0;
            cut  = 1'b0;
            if (sb.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL grant_unexpected at cycle %0d: pulse started, src_id %0h, no grant expected",
                       cyc, bus.src_id);
            end else begin
              g = sb.pop_front();
              check("grant_src",   32'(bus.src_id), 32'(g.src));
              check("grant_cycle", 32'(cyc),        32'(g.at));
            end
          end
          plen++;
        end else if (last_int && !cut) begin
          check("pulse_len", 32'(plen), 32'(P));
        end
        last_int = (bus.interrupt === 1'b1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [N-1:0] rreq;
  logic         rack, rmw, rrst;
  logic [N-1:0] rmd;

  initial begin
    rst          = 1'b1;
    bus.irq_req  = '0;
    bus.id_rd    = 1'b0;
    bus.mask_we  = 1'b0;
    bus.mask_din = '0;

    // Reset held while requests toggle; requests low before release.
    drive(4'hF, 1'b0, 1'b0, '0, 1'b1);
    mon_en = 1'b1;
    drive(4'h5, 1'b1, 1'b0, '0, 1'b1);
    drive(4'h0, 1'b0, 1'b0, '0, 1'b1);
    idle(2, 4'h0);

    // Single request on source 2, acked in WAIT_ACK.
    drive(4'h4, 1'b0, 1'b0, '0, 1'b0);
    idle(8, 4'h4);
    drive(4'h4, 1'b1, 1'b0, '0, 1'b0);
    idle(2, 4'h0);

    // Simultaneous requests on sources 1 and 3.
    drive(4'hA, 1'b0, 1'b0, '0, 1'b0);
    idle(8, 4'hA);
    drive(4'hA, 1'b1, 1'b0, '0, 1'b0);
    idle(8, 4'hA);
    drive(4'hA, 1'b1, 1'b0, '0, 1'b0);
    idle(2, 4'h0);

    // Masked source stays pending, unmask grants it.
    drive(4'h0, 1'b0, 1'b1, 4'h1, 1'b0);
    drive(4'h1, 1'b0, 1'b0, '0, 1'b0);
    idle(4, 4'h1);
    drive(4'h1, 1'b0, 1'b1, 4'h0, 1'b0);
    idle(8, 4'h1);
    drive(4'h1, 1'b1, 1'b0, '0, 1'b0);
    idle(2, 4'h0);

    // Early ack in the third high cycle: full pulse, no WAIT_ACK.
    drive(4'h1, 1'b0, 1'b0, '0, 1'b0);
    idle(3, 4'h1);
    drive(4'h1, 1'b1, 1'b0, '0, 1'b0);
    idle(8, 4'h0);

    // New edge on the granted source together with the ack: re-served.
    drive(4'h4, 1'b0, 1'b0, '0, 1'b0);
    idle(8, 4'h4);
    drive(4'h0, 1'b0, 1'b0, '0, 1'b0);
    drive(4'h4, 1'b1, 1'b0, '0, 1'b0);
    idle(9, 4'h4);
    drive(4'h4, 1'b1, 1'b0, '0, 1'b0);
    idle(2, 4'h0);

    // Reset in the middle of a pulse.
    drive(4'h1, 1'b0, 1'b0, '0, 1'b0);
    idle(3, 4'h1);
    drive(4'h1, 1'b0, 1'b0, '0, 1'b1);
    idle(3, 4'h0);

    // Sources 0 and 1 repeatedly pending together.
    for (int rep = 0; rep < 3; rep++) begin
      drive(4'h3, 1'b0, 1'b0, '0, 1'b0);
      idle(8, 4'h3);
      drive(4'h3, 1'b1, 1'b0, '0, 1'b0);
      idle(8, 4'h3);
      drive(4'h3, 1'b1, 1'b0, '0, 1'b0);
      drive(4'h0, 1'b0, 1'b0, '0, 1'b0);
    end

    // Randomised traffic.
    rreq = '0;
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) rreq[b] = ~rreq[b];
      rack = ($urandom_range(0, 4) == 0);
      rmw  = ($urandom_range(0, 29) == 0);
      rmd  = N'($urandom) & N'($urandom);
      rrst = ($urandom_range(0, 249) == 0);
      drive(rreq, rack, rmw, rmd, rrst);
    end

    // Drain: acknowledge until nothing more is served.
    for (int c = 0; c < 40; c++) drive(4'h0, (c % 8) == 7, 1'b1, 4'h0, 1'b0);
    idle(2, 4'h0);
    @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
